// File: rtl/temp_sample_filter_if.sv
// Sensor/display-facing signals of temp_sample_filter.
// master: the filter side; slave: the sensor and display side.
interface temp_sample_filter_if #(
    parameter int unsigned RAW_W = 8
);
    logic             sample_req;
    logic             raw_valid;
    logic [RAW_W-1:0] raw_data;
    logic [4:0]       temp_out;
    logic             temp_valid;
    logic             sensor_err;

    modport master (
        output sample_req,
        output temp_out,
        output temp_valid,
        output sensor_err,
        input  raw_valid,
        input  raw_data
    );

    modport slave (
        input  sample_req,
        input  temp_out,
        input  temp_valid,
        input  sensor_err,
        output raw_valid,
        output raw_data
    );
endinterface

// File: rtl/temp_sample_filter.sv
// Periodic sensor sampler: averages 2^AVG_LOG2 readings, clamps to 0..30, flags timeouts.
// Optional macro TEMP_HYSTERESIS_EN suppresses updates that move the output by less than 2.
module temp_sample_filter #(
    parameter int unsigned SAMPLE_DIV = 50000,
    parameter int unsigned AVG_LOG2   = 3,
    parameter int unsigned RAW_W      = 8,
    parameter int unsigned TIMEOUT    = 1000
) (
    input logic                 clk,
    input logic                 rst,
    temp_sample_filter_if.master bus
);
    localparam int unsigned TickW    = $clog2(SAMPLE_DIV);
    localparam int unsigned TimeoutW = $clog2(TIMEOUT);
    localparam int unsigned AccW     = RAW_W + AVG_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StUpdate} state_e;

    state_e              state_q, state_d;
    logic [TickW-1:0]    tick_q, tick_d;
    logic [TimeoutW-1:0] to_q, to_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [AccW-1:0]     acc_q, acc_d;
    logic                req_q, req_d;
    logic [4:0]          out_q, out_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic             tick;
    logic [RAW_W-1:0] avg;
    logic [4:0]       clamped;

    assign tick    = (tick_q == TickW'(SAMPLE_DIV - 1));
    assign avg     = acc_q[AccW-1:AVG_LOG2];
    assign clamped = (avg > RAW_W'(30)) ? 5'd30 : avg[4:0];

`ifdef TEMP_HYSTERESIS_EN
    // loaded_q: an update has been accepted since reset, so hysteresis applies.
    logic       loaded_q, loaded_d;
    logic [4:0] diff;

    assign diff = (clamped >= out_q) ? (clamped - out_q) : (out_q - clamped);

    always_ff @(posedge clk) begin
        if (rst) loaded_q <= 1'b0;
        else     loaded_q <= loaded_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tick_q  <= '0;
            to_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            req_q   <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            req_q   <= req_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick ? '0 : tick_q + 1'b1;
        to_d    = to_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        req_d   = 1'b0;
        out_d   = out_q;
        valid_d = 1'b0;
        err_d   = err_q;
`ifdef TEMP_HYSTERESIS_EN
        loaded_d = loaded_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Ticks seen outside IDLE are simply lost.
                if (tick) begin
                    req_d   = 1'b1;
                    to_d    = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                to_d = to_q + 1'b1;
                if (bus.raw_valid) begin
                    acc_d   = acc_q + AccW'(bus.raw_data);
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == '1) ? StUpdate : StIdle;
                end else if (to_q == TimeoutW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StUpdate: begin
                err_d   = 1'b0;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = StIdle;
`ifdef TEMP_HYSTERESIS_EN
                if (!loaded_q || diff >= 5'd2) begin
                    out_d    = clamped;
                    valid_d  = 1'b1;
                    loaded_d = 1'b1;
                end
`else
                out_d   = clamped;
                valid_d = 1'b1;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.sample_req = req_q;
    assign bus.temp_out   = out_q;
    assign bus.temp_valid = valid_q;
    assign bus.sensor_err = err_q;
endmodule

// File: tb/tb_temp_sample_filter.sv
// Directed bench for temp_sample_filter: table of averaging batches plus hand-written
// timeout, reset-mid-batch and spurious-input sequences.
module tb_temp_sample_filter;
    logic clk = 1'b0;
    logic rst;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    temp_sample_filter_if #(.RAW_W(8)) bus ();

    temp_sample_filter #(
        .SAMPLE_DIV(4),
        .AVG_LOG2  (2),
        .RAW_W     (8),
        .TIMEOUT   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0][7:0] samples;
        logic [4:0]      exp_out;
        bit              exp_valid;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Looks at the current cycle first, then advances one negedge at a time.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.sample_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("req_wait_expired", 32'd0, 32'd1);
    endtask

    // Answers one request; with spurious set, an extra raw_valid lands in the IDLE cycle after.
    task automatic send(input logic [7:0] v, input bit spurious);
        bit ok;
        wait_req(ok);
        if (ok) begin
            bus.raw_valid = 1'b1;
            bus.raw_data  = v;
            @(negedge clk);
            check("req_one_cycle", 32'(bus.sample_req), 32'd0);
            if (spurious) begin
                bus.raw_data = 8'hFF;
                @(negedge clk);
            end
            bus.raw_valid = 1'b0;
            bus.raw_data  = 8'h00;
        end
    endtask

    // Called in the cycle after the final raw_valid.
    task automatic finish(input logic [4:0] exp_out, input bit exp_valid, input string name);
        check({name, "_valid_early"}, 32'(bus.temp_valid), 32'd0);
        @(negedge clk);
        check({name, "_valid"}, 32'(bus.temp_valid), 32'(exp_valid));
        check({name, "_out"}, 32'(bus.temp_out), 32'(exp_out));
        check({name, "_err"}, 32'(bus.sensor_err), 32'd0);
        @(negedge clk);
        check({name, "_valid_width"}, 32'(bus.temp_valid), 32'd0);
    endtask

    task automatic batch(input logic [3:0][7:0] s, input logic [4:0] exp_out,
                         input bit exp_valid, input string name);
        for (int i = 0; i < 4; i++) send(s[i], 1'b0);
        finish(exp_out, exp_valid, name);
    endtask

    initial begin
        bit ok;
        bit saw_valid;

        vecs[0].samples = {8'd25, 8'd25, 8'd25, 8'd25}; vecs[0].exp_out = 5'd25; vecs[0].exp_valid = 1;
        vecs[1].samples = {8'd70, 8'd60, 8'd50, 8'd40}; vecs[1].exp_out = 5'd30; vecs[1].exp_valid = 1;
        vecs[2].samples = {8'd11, 8'd11, 8'd11, 8'd10}; vecs[2].exp_out = 5'd10; vecs[2].exp_valid = 1;
        vecs[3].samples = {8'd200, 8'd200, 8'd200, 8'd200}; vecs[3].exp_out = 5'd30;
        vecs[3].exp_valid = 1;
        vecs[4].samples = {8'd20, 8'd20, 8'd20, 8'd20}; vecs[4].exp_out = 5'd20; vecs[4].exp_valid = 1;
        vecs[5].samples = {8'd21, 8'd21, 8'd21, 8'd21};
`ifdef TEMP_HYSTERESIS_EN
        vecs[5].exp_out = 5'd20; vecs[5].exp_valid = 0;
`else
        vecs[5].exp_out = 5'd21; vecs[5].exp_valid = 1;
`endif
        vecs[6].samples = {8'd22, 8'd22, 8'd22, 8'd22}; vecs[6].exp_out = 5'd22; vecs[6].exp_valid = 1;

        rst           = 1'b1;
        bus.raw_valid = 1'b0;
        bus.raw_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_out", 32'(bus.temp_out), 32'd0);
        check("reset_valid", 32'(bus.temp_valid), 32'd0);
        check("reset_err", 32'(bus.sensor_err), 32'd0);
        check("reset_req", 32'(bus.sample_req), 32'd0);
        rst = 1'b0;

        // Steady reading, then an unanswered request.
        batch({8'd25, 8'd25, 8'd25, 8'd25}, 5'd25, 1'b1, "steady");
        wait_req(ok);
        saw_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.temp_valid === 1'b1) saw_valid = 1'b1;
            if (k == 7) check("timeout_err_early", 32'(bus.sensor_err), 32'd0);
        end
        check("timeout_err", 32'(bus.sensor_err), 32'd1);
        check("timeout_out_held", 32'(bus.temp_out), 32'd25);
        check("timeout_no_valid", 32'(saw_valid), 32'd0);
        send(8'd12, 1'b0);
        check("err_sticky", 32'(bus.sensor_err), 32'd1);
        for (int i = 0; i < 3; i++) send(8'd12, 1'b0);
        finish(5'd12, 1'b1, "after_timeout");

        for (int i = 0; i < 7; i++)
            batch(vecs[i].samples, vecs[i].exp_out, vecs[i].exp_valid, $sformatf("vec%0d", i));

        // raw_valid pulses in IDLE carry 255 and must not be accumulated.
        for (int i = 0; i < 3; i++) send(8'd5, 1'b1);
        send(8'd5, 1'b0);
        finish(5'd5, 1'b1, "spurious");

        // Reset mid-batch: the two pre-reset samples must be forgotten.
        send(8'd30, 1'b0);
        send(8'd30, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out", 32'(bus.temp_out), 32'd0);
        check("midrst_valid", 32'(bus.temp_valid), 32'd0);
        check("midrst_err", 32'(bus.sensor_err), 32'd0);
        check("midrst_req", 32'(bus.sample_req), 32'd0);
        send(8'd1, 1'b0);
        send(8'd1, 1'b0);
        check("partial_valid_a", 32'(bus.temp_valid), 32'd0);
        @(negedge clk);
        check("partial_valid_b", 32'(bus.temp_valid), 32'd0);
        check("partial_out", 32'(bus.temp_out), 32'd0);
        send(8'd1, 1'b0);
        send(8'd1, 1'b0);
        finish(5'd1, 1'b1, "first_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
